pipeline_mem: RTL and testbench

Memory (M) stage of the 5-stage RV32I pipeline. It registers the EX-stage control and ALU result into the EX/MEM boundary and performs data-memory stores and loads against an internal synchronous word-organised SRAM. Load data is returned formatted (byte/half/word, sign- or zero-extended) in the same cycle as the registered M-stage signals, for the writeback stage.

---
 rtl/pipeline_mem_pkg.sv | 48 ++++
 rtl/data_sram.sv | 35 +++
 rtl/pipeline_mem.sv | 111 +++++++++++
 tb/tb_pipeline_mem.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mem_pkg.sv
// Shared definitions for the memory stage: op codes, address map and load formatting.
package pipeline_mem_pkg;

    typedef enum logic [3:0] {
        NO_MEM  = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    localparam logic [31:0] MEM_BASE      = 32'h8000_0000;
    localparam logic [29:0] MEM_BASE_WORD = 30'h2000_0000;
    localparam int          MEM_DEPTH     = 816;
    localparam int          IDX_W         = 10;

    // Pick the addressed byte/half out of a memory word and extend it to 32 bits.
    // Non-load op codes (including the unused 9..15) produce zero.
    function automatic logic [31:0] format_load(input logic [3:0]  op,
                                                input logic [31:0] word,
                                                input logic [1:0]  lo);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = 8'h00;
        endcase
        half_v = lo[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_LB:  res_v = {{24{byte_v[7]}}, byte_v};
            MEM_LBU: res_v = {24'h00_0000, byte_v};
            MEM_LH:  res_v = {{16{half_v[15]}}, half_v};
            MEM_LHU: res_v = {16'h0000, half_v};
            MEM_LW:  res_v = word;
            default: res_v = 32'h0000_0000;
        endcase
        return res_v;
    endfunction

endpackage

// File: rtl/data_sram.sv
// 816 x 32 single-port synchronous data RAM with per-byte write mask and registered read.
// Contents are deliberately not reset; a read in the same cycle as a write returns the old word.
module data_sram
    import pipeline_mem_pkg::*;
(
    input  logic             clk,
    input  logic [IDX_W-1:0] word_idx,
    input  logic [3:0]       byte_mask,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data
);

    logic [31:0] m_array [MEM_DEPTH];
    logic [31:0] rd_data_r;

    // Byte-lane masked write; unselected lanes keep their contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_mask[i]) begin
                    m_array[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Registered read port (old-data on a same-address write).
    always_ff @(posedge clk) begin
        rd_data_r <= m_array[word_idx];
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/pipeline_mem.sv
// Memory stage of the RV32I pipeline: EX/MEM boundary registers, store lane
// steering into the data SRAM, range check and load formatting for writeback.
module pipeline_mem
    import pipeline_mem_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        regWriteEnE,
    input  logic [1:0]  resultSrcE,
    input  logic        memWriteEnE,
    input  logic [3:0]  memOpTypeE,
    input  logic [31:0] aluResultE,
    input  logic [31:0] memWriteDataE,
    output logic        regWriteEnM,
    output logic [1:0]  resultSrcM,
    output logic [31:0] aluResultM,
    output logic [31:0] memReadDataM
);

    logic [29:0]      word_off_s;
    logic             in_range_s;
    logic [IDX_W-1:0] sram_idx_s;
    logic             is_store_s;
    logic [3:0]       byte_mask_s;
    logic [31:0]      wr_data_s;
    logic             sram_we_s;
    logic [31:0]      sram_rdata_s;

    logic             reg_write_r;
    logic [1:0]       result_src_r;
    logic [31:0]      alu_result_r;
    logic [3:0]       mem_op_r;
    logic             in_range_r;

    // Addresses below the base wrap to a huge offset and so fail the same compare.
    assign word_off_s = aluResultE[31:2] - MEM_BASE_WORD;
    assign in_range_s = (word_off_s < 30'(MEM_DEPTH));
    assign sram_idx_s = in_range_s ? word_off_s[IDX_W-1:0] : {IDX_W{1'b0}};

    // Store lane selection: replicate the data across lanes and enable only the addressed ones.
    always_comb begin
        is_store_s  = 1'b0;
        byte_mask_s = 4'b0000;
        wr_data_s   = 32'h0000_0000;
        case (memOpTypeE)
            MEM_SB: begin
                is_store_s  = 1'b1;
                byte_mask_s = 4'b0001 << aluResultE[1:0];
                wr_data_s   = {4{memWriteDataE[7:0]}};
            end
            MEM_SH: begin
                is_store_s  = 1'b1;
                byte_mask_s = aluResultE[1] ? 4'b1100 : 4'b0011;
                wr_data_s   = {2{memWriteDataE[15:0]}};
            end
            MEM_SW: begin
                is_store_s  = 1'b1;
                byte_mask_s = 4'b1111;
                wr_data_s   = memWriteDataE;
            end
            default: begin
                is_store_s  = 1'b0;
                byte_mask_s = 4'b0000;
                wr_data_s   = 32'h0000_0000;
            end
        endcase
    end

    // Reset level gates the write so nothing reaches memory while the stage is held in reset.
    assign sram_we_s = memWriteEnE & is_store_s & in_range_s & resetn;

    data_sram sramInstance (
        .clk       (clk),
        .word_idx  (sram_idx_s),
        .byte_mask (byte_mask_s),
        .wr_en     (sram_we_s),
        .wr_data   (wr_data_s),
        .rd_data   (sram_rdata_s)
    );

    // EX/MEM boundary registers; the op and range flag travel with the SRAM read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reg_write_r  <= 1'b0;
            result_src_r <= 2'b00;
            alu_result_r <= 32'h0000_0000;
            mem_op_r     <= NO_MEM;
            in_range_r   <= 1'b0;
        end else begin
            reg_write_r  <= regWriteEnE;
            result_src_r <= resultSrcE;
            alu_result_r <= aluResultE;
            mem_op_r     <= memOpTypeE;
            in_range_r   <= in_range_s;
        end
    end

    // Load formatting from registered state only; out-of-range accesses read as zero.
    always_comb begin
        if (in_range_r) begin
            memReadDataM = format_load(mem_op_r, sram_rdata_s, alu_result_r[1:0]);
        end else begin
            memReadDataM = 32'h0000_0000;
        end
    end

    assign regWriteEnM = reg_write_r;
    assign resultSrcM  = result_src_r;
    assign aluResultM  = alu_result_r;

endmodule

// File: tb/tb_pipeline_mem.sv
// Self-checking bench for pipeline_mem: directed vector table, reset sequences,
// and randomized traffic against a word-array reference model.
module tb_pipeline_mem;

    logic        clk = 1'b0;
    logic        resetn;
    logic        regWriteEnE;
    logic [1:0]  resultSrcE;
    logic        memWriteEnE;
    logic [3:0]  memOpTypeE;
    logic [31:0] aluResultE;
    logic [31:0] memWriteDataE;
    logic        regWriteEnM;
    logic [1:0]  resultSrcM;
    logic [31:0] aluResultM;
    logic [31:0] memReadDataM;

    int passed = 0;
    int total  = 0;

    logic [31:0] model_mem [816];

    typedef struct {
        logic        we;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    pipeline_mem dut (
        .clk           (clk),
        .resetn        (resetn),
        .regWriteEnE   (regWriteEnE),
        .resultSrcE    (resultSrcE),
        .memWriteEnE   (memWriteEnE),
        .memOpTypeE    (memOpTypeE),
        .aluResultE    (aluResultE),
        .memWriteDataE (memWriteDataE),
        .regWriteEnM   (regWriteEnM),
        .resultSrcM    (resultSrcM),
        .aluResultM    (aluResultM),
        .memReadDataM  (memReadDataM)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: byte offset from base, word index, then shift/mask arithmetic.
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
        logic [31:0] off, w, b, h;
        off = addr - 32'h8000_0000;
        if (op < 4'd1 || op > 4'd5) return 32'd0;
        if ((off / 4) >= 32'd816) return 32'd0;
        w = model_mem[off / 4];
        b = (w >> (8 * (addr % 4))) & 32'hFF;
        h = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            4'd1: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            4'd2: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            4'd3: return w;
            4'd4: return b;
            default: return h;
        endcase
    endfunction

    function automatic void model_store(input logic we, input logic [3:0] op,
                                        input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off, w, pos;
        off = addr - 32'h8000_0000;
        if (!we || op < 4'd6 || op > 4'd8) return;
        if ((off / 4) >= 32'd816) return;
        w = model_mem[off / 4];
        if (op == 4'd8) begin
            w = data;
        end else if (op == 4'd7) begin
            pos = 16 * ((addr / 2) % 2);
            w = (w & ~(32'hFFFF << pos)) | ((data & 32'hFFFF) << pos);
        end else begin
            pos = 8 * (addr % 4);
            w = (w & ~(32'hFF << pos)) | ((data & 32'hFF) << pos);
        end
        model_mem[off / 4] = w;
    endfunction

    // One pipeline beat: drive E inputs, clock, compare M outputs with the model.
    task automatic step(input logic we, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic rw, input logic [1:0] rs,
                        output logic [31:0] got_rd);
        logic [31:0] exp_rd;
        memWriteEnE   = we;
        memOpTypeE    = op;
        aluResultE    = addr;
        memWriteDataE = data;
        regWriteEnE   = rw;
        resultSrcE    = rs;
        exp_rd = model_load(op, addr);
        @(posedge clk);
        model_store(we, op, addr, data);
        #1;
        check("regWriteEnM", {31'd0, regWriteEnM}, {31'd0, rw});
        check("resultSrcM", {30'd0, resultSrcM}, {30'd0, rs});
        check("aluResultM", aluResultM, addr);
        check("memReadDataM", memReadDataM, exp_rd);
        got_rd = memReadDataM;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;

        // Reset held across an edge with a live store presented.
        resetn = 1'b0;
        regWriteEnE = 1'b1; resultSrcE = 2'd3; memWriteEnE = 1'b1;
        memOpTypeE = 4'd8; aluResultE = 32'h8000_0000; memWriteDataE = 32'h1234_5678;
        @(posedge clk); #1;
        check("rst_regWriteEnM", {31'd0, regWriteEnM}, 32'd0);
        check("rst_resultSrcM", {30'd0, resultSrcM}, 32'd0);
        check("rst_aluResultM", aluResultM, 32'd0);
        check("rst_memReadDataM", memReadDataM, 32'd0);
        resetn = 1'b1;

        // Directed vectors: {we, op, addr, data, rw, rs, expected memReadDataM}
        vecs.push_back('{1'b1, 4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b1, 4'd8, 32'h8000_0004, 32'hAAAA_AAAA, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b0, 4'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b0, 4'd3, 32'h8000_0000, 32'h0000_0000, 1'b1, 2'd1, 32'hFFFF_FFFF});
        vecs.push_back('{1'b0, 4'd3, 32'h8000_0004, 32'h0000_0000, 1'b1, 2'd1, 32'hAAAA_AAAA});
        vecs.push_back('{1'b1, 4'd8, 32'h8000_0008, 32'h1122_3344, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b1, 4'd6, 32'h8000_0009, 32'hFFFF_FF80, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b0, 4'd3, 32'h8000_0008, 32'h0000_0000, 1'b1, 2'd1, 32'h1122_8044});
        vecs.push_back('{1'b0, 4'd1, 32'h8000_0009, 32'h0000_0000, 1'b1, 2'd1, 32'hFFFF_FF80});
        vecs.push_back('{1'b0, 4'd4, 32'h8000_0009, 32'h0000_0000, 1'b1, 2'd1, 32'h0000_0080});
        vecs.push_back('{1'b1, 4'd8, 32'h8000_0010, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b1, 4'd7, 32'h8000_0012, 32'h1234_BEEF, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b0, 4'd3, 32'h8000_0010, 32'h0000_0000, 1'b1, 2'd1, 32'hBEEF_0000});
        vecs.push_back('{1'b0, 4'd2, 32'h8000_0012, 32'h0000_0000, 1'b1, 2'd1, 32'hFFFF_BEEF});
        vecs.push_back('{1'b0, 4'd5, 32'h8000_0012, 32'h0000_0000, 1'b1, 2'd1, 32'h0000_BEEF});
        vecs.push_back('{1'b0, 4'd8, 32'h8000_0010, 32'h0000_0055, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b1, 4'd9, 32'h8000_0010, 32'hFFFF_FFFF, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b1, 4'd3, 32'h8000_0010, 32'h0000_0001, 1'b0, 2'd0, 32'hBEEF_0000});
        vecs.push_back('{1'b0, 4'd3, 32'h8000_0013, 32'h0000_0000, 1'b1, 2'd1, 32'hBEEF_0000});
        vecs.push_back('{1'b1, 4'd8, 32'h8000_0CC0, 32'hDEAD_BEEF, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b0, 4'd3, 32'h8000_0CC0, 32'h0000_0000, 1'b1, 2'd1, 32'h0000_0000});
        vecs.push_back('{1'b1, 4'd8, 32'h8000_0CBC, 32'h0BAD_F00D, 1'b0, 2'd0, 32'h0000_0000});
        vecs.push_back('{1'b0, 4'd3, 32'h8000_0CBC, 32'h0000_0000, 1'b1, 2'd1, 32'h0BAD_F00D});
        vecs.push_back('{1'b0, 4'd3, 32'h7FFF_FFFC, 32'h0000_0000, 1'b1, 2'd1, 32'h0000_0000});
        vecs.push_back('{1'b0, 4'd0, 32'h1234_5678, 32'h0000_0000, 1'b1, 2'd2, 32'h0000_0000});
        vecs.push_back('{1'b0, 4'd3, 32'h8000_0000, 32'h0000_0000, 1'b1, 2'd1, 32'hFFFF_FFFF});
        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].rw, vecs[i].rs, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end

        // Async reset mid-cycle: outputs clear before any further edge.
        #2 resetn = 1'b0;
        #1;
        check("async_regWriteEnM", {31'd0, regWriteEnM}, 32'd0);
        check("async_resultSrcM", {30'd0, resultSrcM}, 32'd0);
        check("async_aluResultM", aluResultM, 32'd0);
        check("async_memReadDataM", memReadDataM, 32'd0);
        // A store presented during reset must not reach memory.
        memWriteEnE = 1'b1; memOpTypeE = 4'd8; aluResultE = 32'h8000_0000;
        memWriteDataE = 32'h0000_0000; regWriteEnE = 1'b1; resultSrcE = 2'd2;
        @(posedge clk); #1;
        check("inrst_aluResultM", aluResultM, 32'd0);
        resetn = 1'b1;
        step(1'b0, 4'd3, 32'h8000_0000, 32'h0, 1'b0, 2'd0, rd);
        check("rst_store_suppressed", rd, 32'hFFFF_FFFF);

        // Fill every word so the model is fully defined, then random traffic.
        for (int w = 0; w < 816; w++) begin
            step(1'b1, 4'd8, 32'h8000_0000 + 32'(w) * 32'd4, $urandom, 1'b0, 2'd0, rd);
        end
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'h8000_0CC0 + 32'($urandom_range(0, 63));
                default: a = 32'h8000_0000 + 32'($urandom_range(0, 816 * 4 - 1));
            endcase
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), a, $urandom,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
